// File: rtl/memory_pkg.sv
// memory_pkg: shared defaults for the single-port RAM.
//   MEM_WIDTH  default data word width in bits
//   MEM_DEPTH  default number of stored words
//   MEM_ADDR   default address width in bits
//   mem_word_t one default-width data word
package memory_pkg;

  localparam int MEM_WIDTH = 32;
  localparam int MEM_DEPTH = 256;
  localparam int MEM_ADDR  = 8;

  typedef logic [MEM_WIDTH-1:0] mem_word_t;

endpackage

// File: rtl/memory.sv
// memory: single-port synchronous RAM with a valid/ready request handshake.
// One access per valid cycle (write when wrbar=1, read when wrbar=0); ready
// is valid delayed by one clock and rdata is registered.
// Backdoor path to the storage array: <instance>.mem[0..DEPTH-1].
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (clears ready/rdata only)
//   addr   in   word address of the request
//   wdata  in   write data
//   wrbar  in   1 = write, 0 = read
//   rdata  out  registered read data
//   valid  in   request valid
//   ready  out  registered acknowledge
module memory
  import memory_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH,
  parameter int DEPTH = MEM_DEPTH,
  parameter int ADDR  = MEM_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDR-1:0]  addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wrbar,
  output logic [WIDTH-1:0] rdata,
  input  logic             valid,
  output logic             ready
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH held one bit wider than addr so DEPTH == 2**ADDR still compares correctly.
  localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic             r_ready;
  logic [WIDTH-1:0] r_rdata;
  logic             w_in_range;
  logic [IDXW-1:0]  w_idx;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_in_range = ({1'b0, addr} < DEPTH_L);
  assign w_idx      = addr[IDXW-1:0];
  assign w_wr_en    = rst && valid && wrbar && w_in_range;
  assign w_rd_en    = valid && !wrbar;

  // Storage has no reset so contents survive rst; writes are gated by rst instead.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem[w_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= '0;
      r_rdata <= '0;
    end else begin
      r_ready <= valid;
      if (w_rd_en) begin
        r_rdata <= w_in_range ? mem[w_idx] : '0;
      end
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_memory.sv
module tb_memory;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  mem_word_t   wdata;
  logic        wrbar;
  mem_word_t   rdata;
  logic        valid;
  logic        ready;

  logic [3:0]  s_addr;
  logic [15:0] s_wdata;
  logic        s_wrbar;
  logic [15:0] s_rdata;
  logic        s_valid;
  logic        s_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference state for the main instance
  mem_word_t model [0:255];
  logic      e_ready;
  mem_word_t e_rdata;

  always #5 clk = ~clk;

  memory #(.WIDTH(32), .DEPTH(256), .ADDR(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wrbar(wrbar),
    .rdata(rdata), .valid(valid), .ready(ready)
  );

  // narrow, shallow instance: DEPTH < 2**ADDR exposes out-of-range addresses
  memory #(.WIDTH(16), .DEPTH(12), .ADDR(4)) dut_s (
    .clk(clk), .rst(rst), .addr(s_addr), .wdata(s_wdata), .wrbar(s_wrbar),
    .rdata(s_rdata), .valid(s_valid), .ready(s_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one request on the main instance; model follows the access rules directly
  task automatic step(input string tag, input logic v, input logic w,
                      input logic [7:0] a, input mem_word_t d);
    valid = v; wrbar = w; addr = a; wdata = d;
    @(posedge clk);
    if (!rst) begin
      e_ready = 1'b0;
      e_rdata = '0;
    end else if (v) begin
      e_ready = 1'b1;
      if (w) model[a] = d;
      else   e_rdata = model[a];
    end else begin
      e_ready = 1'b0;
    end
    #1;
    chk({tag, ".ready"}, {31'b0, ready}, {31'b0, e_ready});
    chk({tag, ".rdata"}, rdata, e_rdata);
  endtask

  task automatic sstep(input string tag, input logic v, input logic w, input logic [3:0] a,
                       input logic [15:0] d, input logic x_ready, input logic [15:0] x_rdata);
    s_valid = v; s_wrbar = w; s_addr = a; s_wdata = d;
    @(posedge clk);
    #1;
    chk({tag, ".ready"}, {31'b0, s_ready}, {31'b0, x_ready});
    chk({tag, ".rdata"}, {16'b0, s_rdata}, {16'b0, x_rdata});
  endtask

  task automatic bd_load(input int lo, input int hi, input bit pattern);
    for (int i = lo; i <= hi; i++) begin
      mem_word_t v;
      v = pattern ? mem_word_t'(i) : mem_word_t'($urandom);
      dut.mem[i] = v;
      model[i]   = v;
    end
  endtask

  task automatic bd_dump(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) chk(tag, dut.mem[i], model[i]);
  endtask

  initial begin
    mem_word_t  save0;
    logic [7:0] ra;

    rst = 1'b0; valid = 1'b0; wrbar = 1'b0; addr = '0; wdata = '0;
    s_valid = 1'b0; s_wrbar = 1'b0; s_addr = '0; s_wdata = '0;
    e_ready = 1'b0; e_rdata = '0;
    bd_load(0, 255, 1'b0);
    for (int i = 0; i < 12; i++) dut_s.mem[i] = '0;

    // reset held with a pending write: nothing acknowledged, nothing stored
    #1;
    chk("rst.ready0", {31'b0, ready}, 32'd0);
    chk("rst.rdata0", rdata, 32'd0);
    step("rst", 1'b1, 1'b1, 8'd3, 32'h1111_2222);
    step("rst", 1'b1, 1'b1, 8'd3, 32'h3333_4444);
    chk("rst.mem3", dut.mem[3], model[3]);
    rst = 1'b1;
    step("rel", 1'b1, 1'b0, 8'd3, '0);

    // frontdoor write then read, ascending
    for (int i = 0; i < 32; i++) step("wr32", 1'b1, 1'b1, 8'(i), $urandom);
    for (int i = 0; i < 32; i++) step("rd32", 1'b1, 1'b0, 8'(i), $urandom);

    // frontdoor write, backdoor dump
    for (int i = 0; i < 64; i++) step("wr64", 1'b1, 1'b1, 8'(i), $urandom);
    step("idle", 1'b0, 1'b0, '0, '0);
    bd_dump("dump64", 0, 63);

    // backdoor index-pattern load, frontdoor read
    bd_load(0, 127, 1'b1);
    for (int i = 0; i < 128; i++) step("rd128", 1'b1, 1'b0, 8'(i), '0);
    chk("rd128.mem5", dut.mem[5], 32'h0000_0005);

    // full random image, dump, top-address write/read
    step("idle", 1'b0, 1'b0, '0, '0);
    bd_load(0, 255, 1'b0);
    bd_dump("dump256", 0, 255);
    save0 = model[0];
    step("top.wr", 1'b1, 1'b1, 8'd255, 32'hDEAD_BEEF);
    step("top.rd", 1'b1, 1'b0, 8'd255, '0);
    chk("top.rdata", rdata, 32'hDEAD_BEEF);
    step("top.rd0", 1'b1, 1'b0, 8'd0, '0);
    chk("top.addr0", rdata, save0);

    // handshake corners
    step("tog", 1'b1, 1'b0, 8'd7, '0);
    step("tog", 1'b0, 1'b0, 8'd7, '0);
    step("tog", 1'b1, 1'b0, 8'd8, '0);
    step("raw.wr", 1'b1, 1'b1, 8'd10, 32'hA5A5_A5A5);
    step("raw.rd", 1'b1, 1'b0, 8'd10, '0);
    chk("raw.val", rdata, 32'hA5A5_A5A5);

    // random mixed traffic, narrow address window to provoke read-after-write
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom), ra, $urandom);
    end

    // reset asserted mid-burst between edges
    for (int i = 0; i < 4; i++) step("burst", 1'b1, 1'b1, 8'(40 + i), $urandom);
    valid = 1'b1; wrbar = 1'b1; addr = 8'd50; wdata = 32'hCAFE_F00D;
    rst = 1'b0;
    #1;
    chk("mid.ready", {31'b0, ready}, 32'd0);
    chk("mid.rdata", rdata, 32'd0);
    step("mid", 1'b1, 1'b1, 8'd50, 32'hCAFE_F00D);
    chk("mid.mem50", dut.mem[50], model[50]);
    #2 rst = 1'b1;
    step("mid.rd", 1'b1, 1'b0, 8'd50, '0);
    step("mid.rd", 1'b1, 1'b0, 8'd41, '0);

    // out-of-range addresses on the shallow instance
    valid = 1'b0;
    sstep("oor.wr11", 1'b1, 1'b1, 4'd11, 16'h1234, 1'b1, 16'h0000);
    sstep("oor.wr14", 1'b1, 1'b1, 4'd14, 16'hBEEF, 1'b1, 16'h0000);
    sstep("oor.rd11", 1'b1, 1'b0, 4'd11, 16'h0000, 1'b1, 16'h1234);
    sstep("oor.rd14", 1'b1, 1'b0, 4'd14, 16'h0000, 1'b1, 16'h0000);
    sstep("oor.rd0",  1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h0000);
    sstep("oor.rd15", 1'b1, 1'b0, 4'd15, 16'h0000, 1'b1, 16'h0000);
    sstep("oor.idle", 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000);
    chk("oor.mem11", {16'b0, dut_s.mem[11]}, 32'h0000_1234);
    for (int i = 0; i < 11; i++) chk("oor.clean", {16'b0, dut_s.mem[i]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Single-port synchronous RAM with a valid/ready request handshake.
- Parameterised word width, depth and address width.
- One access per accepted cycle: write when wrbar=1, read when wrbar=0.
- Sits behind a simple bus master. The storage array is also reachable hierarchically for backdoor load/dump by verification.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 256, number of words stored.
- ADDR, 8, address width in bits; DEPTH <= 2**ADDR.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- addr  input  ADDR  word address of the request.
- wdata  input  WIDTH  write data.
- wrbar  input  1  access type: 1 = write, 0 = read.
- rdata  output  WIDTH  registered read data.
- valid  input  1  request valid.
- ready  output  1  registered acknowledge.

Behaviour:
- Storage is an unpacked array named mem, indexed 0..DEPTH-1, each entry WIDTH bits. The name and indexing are fixed so benches can backdoor-load and dump it.
- Reset (rst=0, asynchronous): ready=0 and rdata=0 immediately. mem contents are not cleared. While rst=0, no writes occur.
- Every rising edge with rst=1 and valid=1:
  - wrbar=1: mem[addr] <= wdata; rdata holds its value.
  - wrbar=0: rdata <= mem[addr]; mem is unchanged.
  - ready <= 1 in both cases.
- Rising edge with valid=0: ready <= 0; rdata holds; mem unchanged.
- Latency is one cycle. ready is valid delayed by one clock, so ready is high in the cycle after each accepted request.
- Read data is valid whenever ready is high following a read.
- No back-pressure: every valid cycle is accepted. A master holding valid high with stable addr/wrbar repeats the same access each cycle. This is harmless: a repeated write stores the same value; a repeated read returns the same data.
- Back-to-back requests: the address can change every cycle. Each sampled cycle is an independent access, giving full throughput.
- Read and write to the same address cannot occur in the same cycle (single port).
- A read immediately after a write to the same address returns the newly written data.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR): writes are ignored, reads return 0, ready still asserts.
- Reset mid-operation: a request sampled on the same edge that reset is active is dropped, and ready stays 0. After reset release, the first valid edge behaves normally.
- wdata is don't-care on reads; addr and wdata are don't-care when valid=0.
- Unwritten locations read X in simulation, or the backdoor-loaded value if loaded.

Decomposition:
- Shared package: default constants MEM_WIDTH=32, MEM_DEPTH=256, MEM_ADDR=8, and a word typedef of MEM_WIDTH bits.
- No sub-module is required.
- Optional split: a memory_array sub-module (storage plus write/read port) with the handshake/ready register in the top. If split, the hierarchical path to mem must remain documented for backdoor access.

Test Plan:
- Reset: hold rst=0 for 2 cycles with valid=1 → ready=0 and rdata=0 throughout; release rst → ready rises one cycle after the first valid edge.
- Frontdoor write then frontdoor read, ascending: write addr 0..31 with random data (wrbar=1, valid=1, one per cycle), then read 0..31 (wrbar=0) → each rdata equals the written word one cycle after its address; ready high while valid is high.
- Frontdoor write 0..63, backdoor dump of mem[0..63] to a file → file contents match the written data exactly.
- Backdoor load mem[0..127] from a hex file, frontdoor read 0..127 → rdata matches the file, e.g. mem[5]=32'h0000_0005 if the file is an index pattern.
- Backdoor load full DEPTH (0..255), backdoor dump → identical image. Then frontdoor write addr 255 = 32'hDEADBEEF and read addr 255 → 32'hDEADBEEF; addr 0 is untouched.
- Handshake corners: toggle valid 1/0/1 → ready follows with one-cycle delay. Write addr 10 = 32'hA5A5A5A5 then read addr 10 on the next cycle → 32'hA5A5A5A5. Assert rst mid-burst → ready drops asynchronously and the location targeted on that edge is unchanged.
